// File: rtl/turbo_encoder_param_pkg.sv
// turbo_encoder_param_pkg: shared constants, FSM states and tail packing for the LTE turbo encoder.
package turbo_encoder_param_pkg;

    localparam int KMIN = 40;
    // bit i is the coefficient of D^i: g0 = 1+D^2+D^3 (feedback), g1 = 1+D+D^3 (parity)
    localparam logic [3:0] G0 = 4'b1101;
    localparam logic [3:0] G1 = 4'b1011;

    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    typedef struct packed {
        logic [3:0] xk;
        logic [3:0] zk;
        logic [3:0] zkp;
    } tail_t;

    function automatic logic fb(input logic [2:0] s);
        return (G0[1] & s[0]) ^ (G0[2] & s[1]) ^ (G0[3] & s[2]);
    endfunction

    function automatic logic par(input logic a, input logic [2:0] s);
        return (G1[0] & a) ^ (G1[1] & s[0]) ^ (G1[2] & s[1]) ^ (G1[3] & s[2]);
    endfunction

    function automatic tail_t pack_tail(
        input logic [2:0] x1,
        input logic [2:0] z1,
        input logic [2:0] x2,
        input logic [2:0] z2
    );
        tail_t t;
        t.xk  = {z2[1], x2[0], z1[1], x1[0]};
        t.zk  = {x2[2], z2[0], x1[2], z1[0]};
        t.zkp = {z2[2], x2[1], z1[2], x1[1]};
        return t;
    endfunction

endpackage

// File: rtl/turbo_encoder_param_rsc.sv
// rsc_enc_unrolled: combinational P-step RSC encoder plus 3-step trellis termination.
// State bit 0 is the newest delay element.
module rsc_enc_unrolled
    import turbo_encoder_param_pkg::*;
#(
    parameter int P = 8
) (
    input  logic [2:0]   i_state,
    input  logic [P-1:0] i_din,
    output logic [P-1:0] o_parity,
    output logic [2:0]   o_state,
    output logic [2:0]   o_tail_x,
    output logic [2:0]   o_tail_z
);

    logic [2:0] w_s;
    logic [2:0] w_t;
    logic       w_a;

    always_comb begin
        w_s = i_state;
        w_a = 1'b0;
        o_parity = '0;
        for (int i = 0; i < P; i++) begin
            w_a = i_din[i] ^ fb(w_s);
            o_parity[i] = par(w_a, w_s);
            w_s = {w_s[1:0], w_a};
        end
        o_state = w_s;
    end

    // termination drives the input with the feedback so the register shifts in zeros
    always_comb begin
        w_t = i_state;
        o_tail_x = '0;
        o_tail_z = '0;
        for (int i = 0; i < 3; i++) begin
            o_tail_x[i] = fb(w_t);
            o_tail_z[i] = par(1'b0, w_t);
            w_t = {w_t[1:0], 1'b0};
        end
    end

endmodule

// File: rtl/turbo_encoder_param.sv
// turbo_encoder_param: LTE PCCC turbo encoder, P bits per beat through two RSC encoders,
// then one packed trellis-termination beat, behind a single output register stage.
module turbo_encoder_param
    import turbo_encoder_param_pkg::*;
#(
    parameter int P    = 8,
    parameter int KMAX = 6144,
    parameter int KW   = 13
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_start,
    input  logic [KW-1:0] in_k,
    input  logic [P-1:0]  sys_din,
    input  logic [P-1:0]  int_din,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [P-1:0]  xk_out,
    output logic [P-1:0]  zk_out,
    output logic [P-1:0]  zk_prime_out,
    output logic          out_tail,
    output logic          out_last,
    output logic          busy,
    output logic          err
);

    localparam int PL = $clog2(P);

    state_t        r_state, w_next;
    logic [2:0]    r_s1, r_s2, w_ns1, w_ns2, w_es1, w_es2;
    logic [2:0]    w_tx1, w_tz1, w_tx2, w_tz2;
    logic [KW-1:0] r_cnt, w_cnt, w_kbeats;
    logic [P-1:0]  r_xk, r_zk, r_zp, w_p1, w_p2;
    logic          r_out_valid, r_tail, r_err;
    logic          w_slot, w_acc, w_k_ok, w_fresh;
    logic          w_load, w_tail_load, w_clr, w_err;
    tail_t         w_t;

    assign w_slot   = ~r_out_valid | out_ready;
    assign in_ready = (r_state != TAIL) & w_slot & ~reset;
    assign w_acc    = in_valid & in_ready;
    assign w_kbeats = in_k >> PL;
    assign w_k_ok   = (in_k[PL-1:0] == '0) && (in_k >= KW'(KMIN)) && (in_k <= KW'(KMAX));
    // a start beat always encodes from the zero state, even when it truncates a block
    assign w_fresh  = in_start & (r_state != TAIL);
    assign w_es1    = w_fresh ? 3'b000 : r_s1;
    assign w_es2    = w_fresh ? 3'b000 : r_s2;

    rsc_enc_unrolled #(.P(P)) u_enc1 (
        .i_state  (w_es1),
        .i_din    (sys_din),
        .o_parity (w_p1),
        .o_state  (w_ns1),
        .o_tail_x (w_tx1),
        .o_tail_z (w_tz1)
    );

    rsc_enc_unrolled #(.P(P)) u_enc2 (
        .i_state  (w_es2),
        .i_din    (int_din),
        .o_parity (w_p2),
        .o_state  (w_ns2),
        .o_tail_x (w_tx2),
        .o_tail_z (w_tz2)
    );

    assign w_t = pack_tail(w_tx1, w_tz1, w_tx2, w_tz2);

    always_comb begin
        w_next      = r_state;
        w_cnt       = r_cnt;
        w_load      = 1'b0;
        w_tail_load = 1'b0;
        w_clr       = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE, DATA: if (w_acc) begin
                if (in_start) begin
                    w_err  = (r_state == DATA) | ~w_k_ok;
                    w_load = w_k_ok;
                    w_clr  = ~w_k_ok;
                    w_cnt  = w_k_ok ? w_kbeats - KW'(1) : '0;
                    w_next = ~w_k_ok ? IDLE : (w_cnt == '0) ? TAIL : DATA;
                end else if (r_state == DATA) begin
                    w_load = 1'b1;
                    w_cnt  = r_cnt - KW'(1);
                    w_next = (w_cnt == '0) ? TAIL : DATA;
                end
            end
            TAIL: if (w_slot) begin
                w_tail_load = 1'b1;
                w_clr       = 1'b1;
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_s1        <= '0;
            r_s2        <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_xk        <= '0;
            r_zk        <= '0;
            r_zp        <= '0;
            r_tail      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt;
            r_err       <= w_err;
            r_s1        <= w_load ? w_ns1 : w_clr ? 3'b000 : r_s1;
            r_s2        <= w_load ? w_ns2 : w_clr ? 3'b000 : r_s2;
            r_out_valid <= w_load | w_tail_load | (r_out_valid & ~out_ready);
            if (w_load | w_tail_load) begin
                r_xk   <= w_load ? sys_din : P'(w_t.xk);
                r_zk   <= w_load ? w_p1 : P'(w_t.zk);
                r_zp   <= w_load ? w_p2 : P'(w_t.zkp);
                r_tail <= w_tail_load;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign xk_out       = r_xk;
    assign zk_out       = r_zk;
    assign zk_prime_out = r_zp;
    assign out_tail     = r_tail & r_out_valid;
    assign out_last     = r_tail & r_out_valid;
    assign busy         = r_state != IDLE;
    assign err          = r_err;

endmodule

// File: tb/tb_turbo_encoder_param.sv
// tb_turbo_encoder_param: directed checks of the P=8 turbo encoder against hand-derived beats
// and a bit-serial reference for a full-length block under random backpressure.
module tb_turbo_encoder_param;

    localparam int P  = 8;
    localparam int KW = 13;

    typedef struct packed {
        logic         tail;
        logic         last;
        logic [P-1:0] x;
        logic [P-1:0] z;
        logic [P-1:0] zp;
    } beat_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_start;
    logic [KW-1:0] in_k;
    logic [P-1:0]  sys_din;
    logic [P-1:0]  int_din;
    logic          out_valid;
    logic          out_ready;
    logic [P-1:0]  xk_out;
    logic [P-1:0]  zk_out;
    logic [P-1:0]  zk_prime_out;
    logic          out_tail;
    logic          out_last;
    logic          busy;
    logic          err;

    int    checks = 0;
    int    errors = 0;
    int    n_err  = 0;
    int    err0;
    logic  accepted;
    logic  rnd_rdy = 1'b0;
    logic  held    = 1'b0;
    beat_t hold_v;
    beat_t q[$];
    beat_t eq[$];
    logic [P-1:0] sysd [768];
    logic [P-1:0] intd [768];
    logic [P-1:0] imp_x [6] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0A};
    logic [P-1:0] imp_z [6] = '{8'h4F, 8'hA7, 8'hD3, 8'hE9, 8'h74, 8'h0A};

    turbo_encoder_param #(.P(P), .KMAX(6144), .KW(KW)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_start     (in_start),
        .in_k         (in_k),
        .sys_din      (sys_din),
        .int_din      (int_din),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .xk_out       (xk_out),
        .zk_out       (zk_out),
        .zk_prime_out (zk_prime_out),
        .out_tail     (out_tail),
        .out_last     (out_last),
        .busy         (busy),
        .err          (err)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t cur();
        beat_t b;
        b.tail = out_tail;
        b.last = out_last;
        b.x    = xk_out;
        b.z    = zk_out;
        b.zp   = zk_prime_out;
        return b;
    endfunction

    // one clock: sample just after the falling edge, then wait for the next falling edge
    task automatic tick();
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        #1;
        if (held) chk("hold", {out_valid, cur()}, {1'b1, hold_v});
        held   = out_valid && !out_ready;
        hold_v = cur();
        if (out_valid && out_ready) q.push_back(cur());
        accepted = in_valid && in_ready;
        if (err) n_err++;
        @(negedge clock);
    endtask

    task automatic send(input logic [P-1:0] s, input logic [P-1:0] d, input logic st, input logic [KW-1:0] k);
        int n = 0;
        in_valid = 1'b1;
        sys_din  = s;
        int_din  = d;
        in_start = st;
        in_k     = k;
        accepted = 1'b0;
        while (!accepted && n < 2000) begin
            tick();
            n++;
        end
        chk("accept", accepted, 1);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        in_valid = 1'b0;
        in_start = 1'b0;
        tick();
        tick();
        while ((busy || out_valid) && n < limit) begin
            tick();
            n++;
        end
        chk("drain_idle", {busy, out_valid}, 0);
    endtask

    task automatic check_impulse(input string tag, input int base);
        beat_t e;
        for (int i = 0; i < 6; i++) begin
            if (base + i < q.size()) begin
                e      = '0;
                e.x    = imp_x[i];
                e.z    = imp_z[i];
                e.zp   = imp_z[i];
                e.tail = (i == 5);
                e.last = (i == 5);
                chk($sformatf("%s_beat%0d", tag, base + i), q[base+i], e);
            end
        end
    endtask

    task automatic send_impulse40();
        send(8'h01, 8'h01, 1'b1, 13'd40);
        for (int i = 0; i < 4; i++) send(8'h00, 8'h00, 1'b0, 13'd0);
        drain(50);
    endtask

    function automatic logic [3:0] mstep(input logic [2:0] s, input logic c);
        logic a;
        a = c ^ s[1] ^ s[2];
        return {a ^ s[0] ^ s[2], s[1:0], a};
    endfunction

    task automatic build_exp(input int nb);
        logic [2:0] s1 = 3'b000;
        logic [2:0] s2 = 3'b000;
        logic [3:0] r;
        logic [2:0] x1, z1, x2, z2;
        beat_t b;
        eq.delete();
        for (int j = 0; j < nb; j++) begin
            b   = '0;
            b.x = sysd[j];
            for (int i = 0; i < P; i++) begin
                r = mstep(s1, sysd[j][i]); b.z[i]  = r[3]; s1 = r[2:0];
                r = mstep(s2, intd[j][i]); b.zp[i] = r[3]; s2 = r[2:0];
            end
            eq.push_back(b);
        end
        for (int t = 0; t < 3; t++) begin
            x1[t] = s1[1] ^ s1[2]; r = mstep(s1, x1[t]); z1[t] = r[3]; s1 = r[2:0];
            x2[t] = s2[1] ^ s2[2]; r = mstep(s2, x2[t]); z2[t] = r[3]; s2 = r[2:0];
        end
        b = '0;
        b.tail = 1'b1;
        b.last = 1'b1;
        b.x[3:0]  = {z2[1], x2[0], z1[1], x1[0]};
        b.z[3:0]  = {x2[2], z2[0], x1[2], z1[0]};
        b.zp[3:0] = {z2[2], x2[1], z1[2], x1[1]};
        eq.push_back(b);
    endtask

    initial begin
        beat_t e;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_start  = 1'b0;
        in_k      = '0;
        sys_din   = '0;
        int_din   = '0;
        out_ready = 1'b1;
        @(negedge clock);
        tick();
        #1;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_err", err, 0);
        chk("reset_tail", {out_tail, out_last}, 0);
        chk("reset_data", {xk_out, zk_out, zk_prime_out}, 0);
        reset = 1'b0;
        #1;
        chk("idle_in_ready", in_ready, 1);
        @(negedge clock);

        // all-zero block K=40
        q.delete();
        send(8'h00, 8'h00, 1'b1, 13'd40);
        for (int i = 0; i < 4; i++) send(8'h00, 8'h00, 1'b0, 13'd0);
        drain(50);
        chk("zero_count", q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < q.size()) begin
                e = '0;
                e.tail = (i == 5);
                e.last = (i == 5);
                chk($sformatf("zero_beat%0d", i), q[i], e);
            end
        end

        // impulse block K=40
        q.delete();
        send_impulse40();
        chk("impulse_count", q.size(), 6);
        check_impulse("impulse", 0);

        // illegal lengths: discarded with an err pulse
        q.delete();
        err0 = n_err;
        send(8'hFF, 8'hFF, 1'b1, 13'd44);
        drain(20);
        chk("k44_err", n_err - err0, 1);
        chk("k44_noout", q.size(), 0);
        err0 = n_err;
        send(8'hFF, 8'hFF, 1'b1, 13'd6152);
        drain(20);
        chk("k6152_err", n_err - err0, 1);
        chk("k6152_noout", q.size(), 0);
        err0 = n_err;
        send(8'hFF, 8'hFF, 1'b0, 13'd40);
        drain(20);
        chk("nostart_err", n_err - err0, 0);
        chk("nostart_noout", q.size(), 0);

        // restart at beat 3 of K=64 with a fresh K=40 impulse block
        q.delete();
        err0 = n_err;
        send(8'h01, 8'h01, 1'b1, 13'd64);
        send(8'h00, 8'h00, 1'b0, 13'd0);
        send(8'h00, 8'h00, 1'b0, 13'd0);
        send_impulse40();
        chk("restart_err", n_err - err0, 1);
        chk("restart_count", q.size(), 9);
        for (int i = 0; i < 3; i++) begin
            if (i < q.size()) begin
                e    = '0;
                e.x  = imp_x[i];
                e.z  = imp_z[i];
                e.zp = imp_z[i];
                chk($sformatf("restart_old%0d", i), q[i], e);
            end
        end
        check_impulse("restart_new", 3);

        // reset during DATA of K=1056
        send(8'h5A, 8'hC3, 1'b1, 13'd1056);
        for (int i = 0; i < 10; i++) send(8'(i * 37), 8'(i * 11 + 3), 1'b0, 13'd0);
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_in_ready", in_ready, 0);
        reset = 1'b0;
        @(negedge clock);
        q.delete();
        send_impulse40();
        chk("postreset_count", q.size(), 6);
        check_impulse("postreset", 0);

        // K=6144 random data under random backpressure
        for (int j = 0; j < 768; j++) begin
            sysd[j] = 8'($urandom);
            intd[j] = 8'($urandom);
        end
        build_exp(768);
        q.delete();
        rnd_rdy = 1'b1;
        for (int j = 0; j < 768; j++) send(sysd[j], intd[j], j == 0, 13'd6144);
        drain(5000);
        rnd_rdy   = 1'b0;
        out_ready = 1'b1;
        held      = 1'b0;
        chk("rand_count", q.size(), 769);
        for (int j = 0; j < 769; j++) begin
            if (j < q.size()) chk($sformatf("rand_beat%0d", j), q[j], eq[j]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/turbo_encoder_param.md
# turbo_encoder_param

Parametrised LTE turbo encoder core (TS 36.212 PCCC, g0=1+D²+D³ feedback, g1=1+D+D³ parity). Consumes P systematic and P interleaved bits per beat, produces P bits each of xk, zk, zk′ per beat, then one trellis-termination beat. Sits between the code-block segmentation/interleaver front end and the rate-matching stage. Supports any legal block length K (multiple of P, 40..KMAX) and output backpressure.

## Interface
- P, 8, bits per beat (power of two, 4..64)
- KMAX, 6144, largest legal block length
- KW, 13, width of block-length field (≥ clog2(KMAX+1))

Ports:
- clock  in  1  single clock; reset is synchronous and active-high
- reset  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_start  in  1  marks first beat of a block; qualifies in_k
- in_k  in  KW  block length K, sampled on start beat
- sys_din  in  P  systematic bits, bit 0 = earliest
- int_din  in  P  interleaved bits, aligned with sys_din
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- xk_out, zk_out, zk_prime_out  out  P each  systematic / parity1 / parity2, bit 0 earliest
- out_tail  out  1  current beat is the termination beat
- out_last  out  1  last beat of block (always with out_tail)
- busy  out  1  state ≠ IDLE
- err  out  1  one-cycle pulse on rejected length or start-in-block

## Operation
- States IDLE, DATA, TAIL. Reset → IDLE, both encoder states 000, beat counter 0, all outputs 0, in_ready 0 during reset cycle.
- IDLE: accepted beat with in_start and legal K (K%P==0, 40≤K≤KMAX) → load count = K/P, encode beat, count−1; if count hits 0 → TAIL else DATA. Illegal K → beat discarded, err pulse, stay IDLE. Beat without in_start in IDLE → discarded silently.
- DATA: each accepted beat encoded; after final beat → TAIL. Accepted beat with in_start in DATA → err pulse, encoder states cleared, new block begins with that beat (old block truncated, no tail emitted).
- Encoder per bit (state s0 newest): a = c⊕s1⊕s2; z = a⊕s0⊕s2; shift a in. P bits unrolled combinationally per beat; xk = sys_din.
- TAIL: one beat, lowest 4 bits valid, upper bits 0. Termination per 36.212: 3 steps per encoder with input c = s1⊕s2 (a=0), giving x_K..x_K+2, z_K..z_K+2 and primed equivalents. Packing: xk_out[3:0] = {z′K+1, x′K, zK+1, xK}, zk_out[3:0] = {x′K+2, z′K, xK+2, zK}, zk_prime_out[3:0] = {z′K+2, x′K+1, zK+2, xK+1} (bit 0 rightmost). out_tail=out_last=1. After acceptance → IDLE, states cleared.
- in_ready = (IDLE|DATA) & (~out_valid | out_ready) & ~reset.

## Timing
- One output register stage: beat accepted at edge N → out_valid visible after edge N; latency 1.
- Output holds stable while out_valid & ~out_ready; no beat lost or duplicated.
- Tail beat loads at first edge in TAIL where output slot free; full throughput: K/P + 1 beats back-to-back with out_ready=1; next block's start beat accepted the cycle after tail loads.
- Reset mid-block: next cycle IDLE, out_valid 0, partial block abandoned.
- err is registered, asserted the cycle after the offending beat.

## Structure
- Shared package: generator polynomial constants, KMIN=40, state enum {IDLE,DATA,TAIL}, tail bit-packing function.
- One sub-module: rsc_enc_unrolled #(P) — combinational P-step RSC step plus 3-step termination outputs, instanced twice; state registers live in the top.

## Test plan
- P=8, K=40, all-zero input, out_ready=1 → 5 data beats all 0x00, then tail beat all 0, out_last on beat 6.
- P=8, K=40, sys_din=int_din=0x01 first beat then zeros → first beat xk=0x01, zk=0x4F, zk′=0x4F; tail matches reference model.
- K=6144 random data, random out_ready toggling → output stream bit-exact vs golden model, no drops, out_valid held under stall.
- in_k=44 (not multiple of 8) and in_k=6152 → err pulse, no output, stays IDLE.
- in_start mid-block at beat 3 of K=64 → err pulse, new block encoded from zero state, single tail at its end.
- Reset asserted during DATA of K=1056 → out_valid 0 next cycle, following block K=40 encodes correctly; repeat build with P=16.
